// File: rtl/as_gpio_in.sv
// as_gpio_in: memory-mapped GPIO input port.
//
// Each pin passes through a two-flop synchronizer and, when the macro
// AS_GPIO_IN_DEBOUNCE_EN is defined, a per-pin debouncer. Rising edges of the
// debounced state are latched into sticky EDGE flags, and irq_o is the
// registered OR of EDGE & MASK.
//
// Register map (index on addr_i):
//   0 DATA  (RO)  debounced pin state
//   1 EDGE  (W1C) sticky rising-edge flags
//   2 MASK  (RW)  interrupt enable per pin
//   other         reads 0, writes ignored
//
// After reset the block spends a warm-up period (INIT) in which the stable
// state tracks the synchronizer directly and no edges are flagged. This lets
// pins that are already high at power-up settle without raising spurious
// events. INIT is 2+DEBOUNCE_CYC cycles with the debouncer and 2 without it.
module as_gpio_in #(
  parameter int NR_PINS      = 8,
  parameter int ADDR_W       = 8,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NR_PINS-1:0] pins_i,
  input  logic               cs_i,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [63:0]        wdata_i,
  output logic [63:0]        rdata_o,
  output logic               rvalid_o,
  output logic               irq_o
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
`ifdef AS_GPIO_IN_DEBOUNCE_EN
  localparam int INIT_LEN = 2 + DEBOUNCE_CYC;
`else
  localparam int INIT_LEN = 2;
`endif
  localparam int WARM_W = $clog2(INIT_LEN + 1);

  localparam logic [ADDR_W-1:0] IDX_DATA = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] IDX_EDGE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_MASK = ADDR_W'(2);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [WARM_W-1:0]   warm_q, warm_d;
  logic                in_init;

  logic [NR_PINS-1:0]  sync1_q, sync_q;
  logic [NR_PINS-1:0]  data_w;   // debounced pin state as seen by DATA
  logic [NR_PINS-1:0]  rise_w;   // stable 0->1 on the coming edge

  logic [NR_PINS-1:0]  edge_q, edge_d;
  logic [NR_PINS-1:0]  mask_q, mask_d;
  logic [NR_PINS-1:0]  edge_set;
  logic [NR_PINS-1:0]  w1c;

  logic                wr_en, rd_en;
  logic [63:0]         rd_val;
  logic [63:0]         rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                irq_q, irq_d;

  // Only the low NR_PINS bits of the write data carry meaning.
  logic                unused_wdata;
  assign unused_wdata = &{1'b0, wdata_i};

  assign wr_en = cs_i & we_i;
  assign rd_en = cs_i & ~we_i;

  // -------------------------------------------------------------------------
  // Warm-up state machine: INIT for INIT_LEN cycles, then RUN until reset
  // -------------------------------------------------------------------------

  // Next-state logic for the warm-up FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    warm_d  = warm_q;
    unique case (state_q)
      ST_INIT: begin
        if (warm_q == WARM_W'(INIT_LEN - 1)) begin
          state_d = ST_RUN;
          warm_d  = '0;
        end else begin
          warm_d = warm_q + WARM_W'(1);
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
        warm_d  = '0;
      end
    endcase
  end

  // Warm-up FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_INIT;
      warm_q  <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
    end
  end

  assign in_init = (state_q == ST_INIT);

  // -------------------------------------------------------------------------
  // Two-flop synchronizer
  // -------------------------------------------------------------------------

  // Bring the asynchronous pins into the clock domain.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q <= '0;
      sync_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample on the same
      // edge; blocking ones would collapse the chain into a single stage.
      sync1_q <= pins_i;
      sync_q  <= sync1_q;
    end
  end

`ifdef AS_GPIO_IN_DEBOUNCE_EN
  // -------------------------------------------------------------------------
  // Per-pin debouncer
  // -------------------------------------------------------------------------
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [NR_PINS-1:0] stable_q, stable_d;
  logic [CNT_W-1:0]   cnt_q [NR_PINS];
  logic [CNT_W-1:0]   cnt_d [NR_PINS];

  // Count consecutive cycles the synchronized pin disagrees with the stable
  // value; accept the new value once it has disagreed DEBOUNCE_CYC times.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NR_PINS; i++) begin
      cnt_d[i] = '0;
      if (in_init) begin
        stable_d[i] = sync_q[i];
      end else if (sync_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
          stable_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stable_q <= '0;
      // NOTE: this array is a handful of small counters in flops, not a RAM,
      // so every entry is reset explicitly to a known value.
      for (int i = 0; i < NR_PINS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < NR_PINS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign data_w = stable_q;
  assign rise_w = stable_d & ~stable_q;
`else
  // -------------------------------------------------------------------------
  // No debouncer: the stable state is the synchronizer output itself
  // -------------------------------------------------------------------------
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYC > 0);

  assign data_w = sync_q;
  assign rise_w = sync1_q & ~sync_q;
`endif

  // No edges are recorded while the inputs are still settling.
  assign edge_set = in_init ? '0 : rise_w;

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------

  // Decode writes into W1C bits for EDGE and a new value for MASK.
  always_comb begin
    w1c    = '0;
    mask_d = mask_q;
    if (wr_en && addr_i == IDX_EDGE) begin
      w1c = wdata_i[NR_PINS-1:0];
    end
    if (wr_en && addr_i == IDX_MASK) begin
      mask_d = wdata_i[NR_PINS-1:0];
    end
    // A new edge wins over a clear of the same bit.
    edge_d = (edge_q & ~w1c) | edge_set;
  end

  // Read mux over the pre-edge register values, plus the interrupt level.
  always_comb begin
    rd_val = '0;
    case (addr_i)
      IDX_DATA: rd_val = 64'(data_w);
      IDX_EDGE: rd_val = 64'(edge_q);
      IDX_MASK: rd_val = 64'(mask_q);
      default:  rd_val = '0;
    endcase
    rvalid_d = rd_en;
    rdata_d  = rd_en ? rd_val : '0;
    irq_d    = |(edge_q & mask_q);
  end

  // Register state and registered bus/interrupt outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      edge_q   <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      edge_q   <= edge_d;
      mask_q   <= mask_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      irq_q    <= irq_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_as_gpio_in.sv
// Self-checking bench for as_gpio_in: directed scenarios followed by random
// pin and bus traffic, checked every cycle against a cycle-level reference
// model of the register map and the pin filtering rules.
module tb_as_gpio_in;

  localparam int NR_PINS = 8;
  localparam int ADDR_W  = 8;
  localparam int D       = 4;
`ifdef AS_GPIO_IN_DEBOUNCE_EN
  localparam int LAT = 2 + D;
  localparam bit DEB = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit DEB = 1'b0;
`endif
  localparam int INIT_LEN = LAT;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic [NR_PINS-1:0] pins_i;
  logic               cs_i;
  logic               we_i;
  logic [ADDR_W-1:0]  addr_i;
  logic [63:0]        wdata_i;
  logic [63:0]        rdata_o;
  logic               rvalid_o;
  logic               irq_o;

  as_gpio_in #(
    .NR_PINS     (NR_PINS),
    .ADDR_W      (ADDR_W),
    .DEBOUNCE_CYC(D)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .pins_i  (pins_i),
    .cs_i    (cs_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .rvalid_o(rvalid_o),
    .irq_o   (irq_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model. Pins reach "sync" two clocks after sampling; with the
  // debouncer, a pin's accepted value changes once sync has disagreed with
  // it for D clocks in a row. Registers and outputs follow the register map.
  // -------------------------------------------------------------------------
  logic [NR_PINS-1:0] m_s1, m_s2, m_data, m_edge, m_mask;
  int                 m_run [NR_PINS];
  int                 m_cyc;
  logic               m_rvalid, m_irq;
  logic [63:0]        m_rdata;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_s1 <= '0; m_s2 <= '0; m_data <= '0; m_edge <= '0; m_mask <= '0;
      m_cyc <= 0; m_rvalid <= 1'b0; m_irq <= 1'b0; m_rdata <= '0;
      for (int i = 0; i < NR_PINS; i++) m_run[i] <= 0;
    end else begin : step
      logic [NR_PINS-1:0] nd, rise, clr;
      logic [63:0]        rv;
      bit                 init;
      int                 nrun [NR_PINS];
      init = (m_cyc < INIT_LEN);
      nd   = m_data;
      for (int i = 0; i < NR_PINS; i++) nrun[i] = m_run[i];
`ifdef AS_GPIO_IN_DEBOUNCE_EN
      for (int i = 0; i < NR_PINS; i++) begin
        if (init) begin
          nd[i] = m_s2[i];
          nrun[i] = 0;
        end else if (m_s2[i] !== m_data[i]) begin
          nrun[i] = nrun[i] + 1;
          if (nrun[i] == D) begin
            nd[i] = m_s2[i];
            nrun[i] = 0;
          end
        end else begin
          nrun[i] = 0;
        end
      end
`else
      nd = m_s1;
`endif
      rise = init ? '0 : (nd & ~m_data);
      clr  = (cs_i && we_i && addr_i == 8'd1) ? wdata_i[NR_PINS-1:0] : '0;
      rv   = '0;
      if (cs_i && !we_i) begin
        if (addr_i == 8'd0) rv = 64'(m_data);
        else if (addr_i == 8'd1) rv = 64'(m_edge);
        else if (addr_i == 8'd2) rv = 64'(m_mask);
      end
      m_rvalid <= cs_i && !we_i;
      m_rdata  <= rv;
      m_irq    <= |(m_edge & m_mask);
      m_edge   <= (m_edge & ~clr) | rise;
      if (cs_i && we_i && addr_i == 8'd2) m_mask <= wdata_i[NR_PINS-1:0];
      m_data <= nd;
      m_s2   <= m_s1;
      m_s1   <= pins_i;
      for (int i = 0; i < NR_PINS; i++) m_run[i] <= nrun[i];
      if (m_cyc < 1000) m_cyc <= m_cyc + 1;
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("rvalid", 64'(rvalid_o), 64'(m_rvalid));
      check("rdata", rdata_o, m_rdata);
      check("irq", 64'(irq_o), 64'(m_irq));
    end
  end

  // -------------------------------------------------------------------------
  // Bus helpers
  // -------------------------------------------------------------------------
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [63:0] d);
    @(negedge clk_i);
    cs_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
    @(negedge clk_i);
    cs_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, output logic [63:0] d);
    @(negedge clk_i);
    cs_i = 1'b1; we_i = 1'b0; addr_i = a;
    @(negedge clk_i);
    cs_i = 1'b0;
    d = rdata_o;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  logic [63:0] rd;
  logic [63:0] got [4];
  int          nvalid;

  initial begin
    rst_i = 1'b0; pins_i = 8'hFF; cs_i = 1'b0; we_i = 1'b0;
    addr_i = '0; wdata_i = '0;
    #1 chk_en = 1'b1;

    // Reset state with all pins high.
    idle(3);
    check("rst_rvalid", 64'(rvalid_o), 64'h0);
    check("rst_rdata", rdata_o, 64'h0);
    check("rst_irq", 64'(irq_o), 64'h0);
    rst_i = 1'b1;
    idle(10);
    do_read(8'd0, rd); check("init_data", rd, 64'hFF);
    do_read(8'd1, rd); check("init_edge", rd, 64'h00);
    check("init_irq", 64'(irq_o), 64'h0);

    // Pin 0 rising edge latency, with MASK enabling pin 0.
    pins_i = 8'h00;
    idle(LAT + 3);
    do_write(8'd2, 64'h01);
    @(negedge clk_i);
    pins_i = 8'h01; cs_i = 1'b1; we_i = 1'b0; addr_i = 8'd0;
    for (int j = 1; j <= LAT + 1; j++) begin
      @(negedge clk_i);
      check($sformatf("lat_data_e%0d", j), 64'(rdata_o[0]), 64'(j == LAT + 1));
      check($sformatf("lat_irq_e%0d", j), 64'(irq_o), 64'(j == LAT + 1));
    end
    cs_i = 1'b0;
    do_read(8'd1, rd); check("lat_edge", rd, 64'h01);

    // Short glitch on pin 1.
    do_write(8'd1, 64'h01);
    @(negedge clk_i); pins_i = 8'h03;
    idle(3);
    pins_i = 8'h01;
    idle(LAT + 4);
    do_read(8'd1, rd); check("glitch_edge", rd, DEB ? 64'h00 : 64'h02);
    do_read(8'd0, rd); check("glitch_data", rd, 64'h01);

    // W1C behaviour.
    do_write(8'd1, 64'hFF);
    pins_i = 8'h00; idle(LAT + 3);
    pins_i = 8'h03; idle(LAT + 3);
    do_read(8'd1, rd); check("w1c_pre", rd, 64'h03);
    do_write(8'd1, 64'h01);
    do_read(8'd1, rd); check("w1c_post", rd, 64'h02);

    // W1C on the same edge as a new rise on pin 1: set wins.
    pins_i = 8'h01; idle(LAT + 3);
    @(negedge clk_i); pins_i = 8'h03;
    idle(LAT - 1);
    cs_i = 1'b1; we_i = 1'b1; addr_i = 8'd1; wdata_i = 64'h02;
    @(negedge clk_i); cs_i = 1'b0; we_i = 1'b0;
    do_read(8'd1, rd); check("set_wins", rd, 64'h02);

    // Read of EDGE on the same edge as a new rise on pin 0: pre-edge value.
    pins_i = 8'h02; idle(LAT + 3);
    @(negedge clk_i); pins_i = 8'h03;
    idle(LAT - 1);
    cs_i = 1'b1; we_i = 1'b0; addr_i = 8'd1;
    @(negedge clk_i); cs_i = 1'b0;
    check("read_pre_edge", rdata_o, 64'h02);
    do_read(8'd1, rd); check("read_post_edge", rd, 64'h03);

    // Back-to-back reads of 0, 1, 2, 7.
    nvalid = 0;
    @(negedge clk_i);
    cs_i = 1'b1; we_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      addr_i = (k == 3) ? 8'd7 : 8'(k);
      @(negedge clk_i);
      got[k] = rdata_o;
      if (rvalid_o) nvalid++;
    end
    cs_i = 1'b0;
    check("b2b_count", 64'(nvalid), 64'd4);
    check("b2b_data", got[0], 64'h03);
    check("b2b_edge", got[1], 64'h03);
    check("b2b_mask", got[2], 64'h01);
    check("b2b_idx7", got[3], 64'h00);

    // Reset between a read and its response.
    pins_i = 8'h00; idle(LAT + 3);
    do_write(8'd2, 64'hAA);
    @(negedge clk_i);
    cs_i = 1'b1; we_i = 1'b0; addr_i = 8'd2;
    #2 rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("rst_drop_rvalid", 64'(rvalid_o), 64'h0);
    cs_i = 1'b0;
    idle(2);
    rst_i = 1'b1;
    do_read(8'd0, rd); check("rst_data", rd, 64'h0);
    do_read(8'd1, rd); check("rst_edge", rd, 64'h0);
    do_read(8'd2, rd); check("rst_mask", rd, 64'h0);

    // Random pin and bus traffic.
    for (int c = 0; c < 3000; c++) begin
      int sel;
      @(negedge clk_i);
      if ($urandom_range(5) == 0) begin
        sel = $urandom_range(NR_PINS - 1);
        pins_i[sel] = ~pins_i[sel];
      end
      if ($urandom_range(9) < 4) begin
        cs_i = 1'b0;
      end else begin
        cs_i = 1'b1;
        we_i = ($urandom_range(2) == 0);
        sel = $urandom_range(4);
        addr_i = (sel == 4) ? 8'($urandom_range(255)) : 8'(sel);
        wdata_i = {$urandom, $urandom};
      end
    end
    cs_i = 1'b0; we_i = 1'b0;
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
